rd_rsp_sched: RTL and testbench
===============================

Name: rd_rsp_sched

Overview:
- In-order read-response scheduler in front of the DMA read reorder buffer.
- Allocates read tags round-robin to outgoing DMA read requests and records per-tag completion when the reorder buffer has stored a tag's final sub-response.
- Drains tags strictly in allocation order through the buffer's fetch port, with credit-based flow control into a 4-entry output FIFO.
- Frees each tag after its last beat has been fetched.

Parameters:
- TAG_NUM_LOG, 6, log2 of tag count; tags 0..2^TAG_NUM_LOG-1.
- DATA_W, 256, fetch/output data width.
- BCNT_W, 8, width of per-tag beat count.

Ports:
- dma_clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alloc_req  in  1  requester wants a tag.
- alloc_gnt  out  1  tag granted this cycle; equals alloc_req & ~full.
- alloc_tag  out  TAG_NUM_LOG  granted tag; equals alloc_ptr.
- cpl_vld  in  1  tag fully stored in the reorder buffer.
- cpl_tag  in  TAG_NUM_LOG  completed tag.
- cpl_bcnt  in  BCNT_W  beats stored for that tag (1..2^BCNT_W-1).
- ft_rd_rsp_ren  out  1  fetch one beat.
- ft_rd_rsp_tag  out  TAG_NUM_LOG  fetch tag.
- ft_rd_rsp_data  in  DATA_W  returned beat.
- ft_rd_rsp_last  in  1  returned beat is the tag's last.
- ft_rd_rsp_vld  in  1  returned beat valid; arrives 1..3 cycles after its ren, in issue order.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat data.
- out_last  out  1  last beat of a tag.
- out_tag  out  TAG_NUM_LOG  tag of the output beat.
- out_ready  in  1  downstream accepts.
- outstanding  out  TAG_NUM_LOG+1  allocated-but-unreleased tag count.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst high at a dma_clk edge): alloc_ptr=head_ptr=0, outstanding=0, all done bits=0, FIFO empty, in-flight=0, state=IDLE, err=0.
- Reset outputs: alloc_gnt=0 only if alloc_req=0 (combinational); ft_rd_rsp_ren=0, out_valid=0, err=0.
- Reset mid-operation discards all state. Beats returning after reset are ignored.
- Allocation:
  - full = (outstanding == 2^TAG_NUM_LOG).
  - On grant, alloc_ptr increments modulo 2^TAG_NUM_LOG (wraps) and the tag's done bit clears.
  - outstanding is +1 on grant, -1 on release, unchanged when both occur in the same cycle.
  - A release in cycle N lets the freed slot be granted in cycle N+1, not N.
- Completion:
  - On cpl_vld, set done[cpl_tag] and store bcnt[cpl_tag].
  - If cpl_tag is not currently allocated, or is already done, the completion is ignored and err sets.
  - cpl_bcnt=0 sets err, and bcnt is stored as 1.
  - A completion on the head tag is visible to the FSM the next cycle.
- Credits: credit = 4 - (fifo_count + inflight). inflight increments on ren and decrements on ft_rd_rsp_vld.
- FSM:
  - IDLE: if outstanding>0 and done[head_ptr], load beats_left=bcnt[head_ptr] and go to FETCH.
  - FETCH: ft_rd_rsp_ren=1 and ft_rd_rsp_tag=head_ptr whenever credit>0, decrementing beats_left. When the final ren issues, go to DRAIN.
  - DRAIN: wait until the final beat is returned (inflight reaches 0 for this tag). Then go to RELEASE.
  - RELEASE (1 cycle): head_ptr++ (wraps), outstanding--, done[head] cleared. Go to IDLE.
  - Minimum per-tag overhead: 2 idle cycles (RELEASE plus IDLE evaluation).
- Return check: ft_rd_rsp_last must be 1 exactly on the bcnt-th returned beat of the tag. Otherwise err sets, and the scheduler still uses its own count for out_last.
- Output FIFO:
  - 4 entries, first-word fall-through. out_valid = ~empty.
  - Pop on out_valid & out_ready. Push on ft_rd_rsp_vld; credits guarantee it is never full on push.
  - Simultaneous push and pop leaves the count unchanged.
  - out_valid is held, with data stable, until accepted.
- ft_rd_rsp_vld with inflight=0 is ignored and sets err.
- All counters wrap cleanly; ren never issues while credit=0.

Test Plan:
- Reset, then alloc_req=1 for 3 cycles → alloc_tag 0,1,2 with alloc_gnt=1; outstanding=3; no ren issued.
- Completions out of order (tag 2 bcnt=1, tag 0 bcnt=2, tag 1 bcnt=3), out_ready=1, fetch latency 1 → output tag sequence 0,0,1,1,1,2; out_last on the 2nd, 5th, 6th beats; outstanding returns to 0; err=0.
- out_ready=0 with tag 0 bcnt=8 → exactly 4 ren issued, then stalls. Raising out_ready → remaining 4 ren issue; 8 beats delivered in order.
- Allocate all 64 tags → alloc_gnt=0 on the 65th request. Complete and drain tag 0 → grant of tag 0 (wrap) on the cycle after RELEASE.
- cpl_vld for an unallocated tag 5 → err=1 (sticky); done table unchanged; subsequent traffic correct.
- Tag with bcnt=2 returning last=1 on beat 1 → err=1; out_last asserted on beat 2 only.
- Reset asserted during FETCH → all outputs return to reset values next cycle; a fresh allocation returns tag 0.

Source files
------------

// File: rtl/rd_rsp_sched.sv
// In-order read-response scheduler. Hands out DMA read tags round-robin,
// records which tags the reorder buffer has fully stored, and drains them
// strictly in allocation order through the fetch port into a 4-entry
// first-word-fall-through output FIFO, using credits so the FIFO never
// overflows.
module rd_rsp_sched #(
   parameter int TAG_NUM_LOG = 6,
   parameter int DATA_W      = 256,
   parameter int BCNT_W      = 8
) (
   input  logic                   dma_clk,
   input  logic                   rst,
   input  logic                   alloc_req,
   output logic                   alloc_gnt,
   output logic [TAG_NUM_LOG-1:0] alloc_tag,
   input  logic                   cpl_vld,
   input  logic [TAG_NUM_LOG-1:0] cpl_tag,
   input  logic [BCNT_W-1:0]      cpl_bcnt,
   output logic                   ft_rd_rsp_ren,
   output logic [TAG_NUM_LOG-1:0] ft_rd_rsp_tag,
   input  logic [DATA_W-1:0]      ft_rd_rsp_data,
   input  logic                   ft_rd_rsp_last,
   input  logic                   ft_rd_rsp_vld,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_last,
   output logic [TAG_NUM_LOG-1:0] out_tag,
   input  logic                   out_ready,
   output logic [TAG_NUM_LOG:0]   outstanding,
   output logic                   err
);

   localparam int TAG_NUM = 1 << TAG_NUM_LOG;
   localparam int FIFO_D  = 4;
   localparam logic [TAG_NUM_LOG:0] L_TAG_FULL = (TAG_NUM_LOG+1)'(TAG_NUM);
   // Cycles after reset during which returning beats belong to fetches
   // issued before reset (maximum fetch latency) and are dropped silently.
   localparam logic [1:0] L_QUIET = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_RELEASE
   } state_t;

   // Tag bookkeeping
   logic [TAG_NUM_LOG-1:0] r_alloc_ptr;
   logic [TAG_NUM_LOG-1:0] r_head_ptr;
   logic [TAG_NUM_LOG:0]   r_outstanding;
   logic [TAG_NUM-1:0]     r_done;
   logic [BCNT_W-1:0]      r_bcnt [TAG_NUM];

   // Drain FSM
   state_t                 r_state;
   logic [BCNT_W-1:0]      r_beats_left;
   logic [BCNT_W-1:0]      r_ret_cnt;
   logic [BCNT_W-1:0]      r_cur_bcnt;
   logic                   r_ren;
   logic [TAG_NUM_LOG-1:0] r_ren_tag;

   // Flow control and error
   logic [2:0]             r_inflight;
   logic [1:0]             r_quiet;
   logic                   r_err;

   // Output FIFO
   logic [DATA_W-1:0]      r_fifo_data [FIFO_D];
   logic                   r_fifo_last [FIFO_D];
   logic [TAG_NUM_LOG-1:0] r_fifo_tag  [FIFO_D];
   logic [1:0]             r_wr_ptr;
   logic [1:0]             r_rd_ptr;
   logic [2:0]             r_fifo_cnt;

   logic                   w_full;
   logic                   w_grant;
   logic                   w_release;
   logic [TAG_NUM_LOG-1:0] w_cpl_off;
   logic                   w_cpl_alloc;
   logic                   w_cpl_ok;
   logic                   w_cpl_bad;
   logic [BCNT_W-1:0]      w_cpl_bcnt;
   logic [2:0]             w_credit;
   logic                   w_issue;
   logic                   w_rsp_acc;
   logic                   w_rsp_stray;
   logic                   w_ret_last;
   logic                   w_last_bad;
   logic                   w_pop;

   assign w_full      = (r_outstanding == L_TAG_FULL);
   assign w_grant     = alloc_req & ~w_full;
   assign w_release   = (r_state == S_RELEASE);

   // A tag is live when its distance from the head is below the live count.
   assign w_cpl_off   = cpl_tag - r_head_ptr;
   assign w_cpl_alloc = ({1'b0, w_cpl_off} < r_outstanding);
   assign w_cpl_ok    = cpl_vld & w_cpl_alloc & ~r_done[cpl_tag];
   assign w_cpl_bad   = cpl_vld & (~w_cpl_ok | (cpl_bcnt == '0));
   assign w_cpl_bcnt  = (cpl_bcnt == '0) ? BCNT_W'(1) : cpl_bcnt;

   assign w_credit    = 3'd4 - (r_fifo_cnt + r_inflight);
   assign w_issue     = (r_state == S_FETCH) & (w_credit != 3'd0);

   assign w_rsp_acc   = ft_rd_rsp_vld & (r_quiet == 2'd0) & (r_inflight != 3'd0);
   assign w_rsp_stray = ft_rd_rsp_vld & (r_quiet == 2'd0) & (r_inflight == 3'd0);
   // The scheduler's own beat count decides out_last; the buffer's flag is only checked.
   assign w_ret_last  = ((r_ret_cnt + BCNT_W'(1)) == r_cur_bcnt);
   assign w_last_bad  = w_rsp_acc & (ft_rd_rsp_last != w_ret_last);

   assign w_pop       = (r_fifo_cnt != 3'd0) & out_ready;

   // Drain FSM: wait for head completion, issue fetches under credit, wait for returns, release
   always_ff @(posedge dma_clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_beats_left <= '0;
         r_ret_cnt    <= '0;
         r_cur_bcnt   <= '0;
         r_ren        <= 1'b0;
         r_ren_tag    <= '0;
      end else begin
         r_ren <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if ((r_outstanding != '0) && r_done[r_head_ptr]) begin
                  r_beats_left <= r_bcnt[r_head_ptr];
                  r_cur_bcnt   <= r_bcnt[r_head_ptr];
                  r_ret_cnt    <= '0;
                  r_state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (w_issue) begin
                  r_ren        <= 1'b1;
                  r_ren_tag    <= r_head_ptr;
                  r_beats_left <= r_beats_left - BCNT_W'(1);
                  if (r_beats_left == BCNT_W'(1)) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (r_inflight == 3'd0) begin
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         if (w_rsp_acc) begin
            r_ret_cnt <= r_ret_cnt + BCNT_W'(1);
         end
      end
   end

   // Pointers, live-tag count, in-flight fetch count, post-reset quiet window, sticky error
   always_ff @(posedge dma_clk) begin
      if (rst) begin
         r_alloc_ptr   <= '0;
         r_head_ptr    <= '0;
         r_outstanding <= '0;
         r_inflight    <= 3'd0;
         r_quiet       <= L_QUIET;
         r_err         <= 1'b0;
      end else begin
         if (w_grant) begin
            r_alloc_ptr <= r_alloc_ptr + TAG_NUM_LOG'(1);
         end
         if (w_release) begin
            r_head_ptr <= r_head_ptr + TAG_NUM_LOG'(1);
         end
         case ({w_grant, w_release})
            2'b10:   r_outstanding <= r_outstanding + (TAG_NUM_LOG+1)'(1);
            2'b01:   r_outstanding <= r_outstanding - (TAG_NUM_LOG+1)'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         r_inflight <= r_inflight + {2'b00, w_issue} - {2'b00, w_rsp_acc};
         if (r_quiet != 2'd0) begin
            r_quiet <= r_quiet - 2'd1;
         end
         if (w_cpl_bad | w_last_bad | w_rsp_stray) begin
            r_err <= 1'b1;
         end
      end
   end

   // Done bits: cleared on grant and on release, set by a legal completion
   always_ff @(posedge dma_clk) begin
      if (rst) begin
         r_done <= '0;
      end else begin
         if (w_grant) begin
            r_done[r_alloc_ptr] <= 1'b0;
         end
         if (w_release) begin
            r_done[r_head_ptr] <= 1'b0;
         end
         if (w_cpl_ok) begin
            r_done[cpl_tag] <= 1'b1;
         end
      end
   end

   // Beat count table; only read for tags whose done bit is set
   always_ff @(posedge dma_clk) begin
      if (w_cpl_ok) begin
         r_bcnt[cpl_tag] <= w_cpl_bcnt;
      end
   end

   // Output FIFO pointers and occupancy
   always_ff @(posedge dma_clk) begin
      if (rst) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_fifo_cnt <= 3'd0;
      end else begin
         if (w_rsp_acc) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         r_fifo_cnt <= r_fifo_cnt + {2'b00, w_rsp_acc} - {2'b00, w_pop};
      end
   end

   // Output FIFO storage; returned beats are tagged with the current head
   always_ff @(posedge dma_clk) begin
      if (w_rsp_acc) begin
         r_fifo_data[r_wr_ptr] <= ft_rd_rsp_data;
         r_fifo_last[r_wr_ptr] <= w_ret_last;
         r_fifo_tag[r_wr_ptr]  <= r_head_ptr;
      end
   end

   assign alloc_gnt     = w_grant;
   assign alloc_tag     = r_alloc_ptr;
   assign ft_rd_rsp_ren = r_ren;
   assign ft_rd_rsp_tag = r_ren_tag;
   assign out_valid     = (r_fifo_cnt != 3'd0);
   assign out_data      = r_fifo_data[r_rd_ptr];
   assign out_last      = r_fifo_last[r_rd_ptr];
   assign out_tag       = r_fifo_tag[r_rd_ptr];
   assign outstanding   = r_outstanding;
   assign err           = r_err;

endmodule

// File: tb/tb_rd_rsp_sched.sv
// Scoreboard bench for rd_rsp_sched: a fetch-port responder with 1..3 cycle
// in-order latency, a tag-order reference model, and an output monitor.
module tb_rd_rsp_sched;

   localparam int TL = 6;
   localparam int DW = 256;
   localparam int BW = 8;
   localparam int NT = 64;

   logic          dma_clk = 1'b0;
   logic          rst;
   logic          alloc_req;
   logic          alloc_gnt;
   logic [TL-1:0] alloc_tag;
   logic          cpl_vld;
   logic [TL-1:0] cpl_tag;
   logic [BW-1:0] cpl_bcnt;
   logic          ft_rd_rsp_ren;
   logic [TL-1:0] ft_rd_rsp_tag;
   logic [DW-1:0] ft_rd_rsp_data;
   logic          ft_rd_rsp_last;
   logic          ft_rd_rsp_vld;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [TL-1:0] out_tag;
   logic          out_ready;
   logic [TL:0]   outstanding;
   logic          err;

   rd_rsp_sched #(.TAG_NUM_LOG(TL), .DATA_W(DW), .BCNT_W(BW)) dut (
      .dma_clk(dma_clk), .rst(rst),
      .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .cpl_bcnt(cpl_bcnt),
      .ft_rd_rsp_ren(ft_rd_rsp_ren), .ft_rd_rsp_tag(ft_rd_rsp_tag),
      .ft_rd_rsp_data(ft_rd_rsp_data), .ft_rd_rsp_last(ft_rd_rsp_last),
      .ft_rd_rsp_vld(ft_rd_rsp_vld),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_tag(out_tag), .out_ready(out_ready),
      .outstanding(outstanding), .err(err)
   );

   always #5 dma_clk = ~dma_clk;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
      bit            last;
   } beat_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ren_cnt = 0;

   // Reference model: tags in allocation order, completion table, expected streams
   int            alloc_q[$];
   int            mbcnt[NT];
   bit            mdone[NT];
   int            idx[NT];
   int            next_tag;
   int            m_live;
   int            exp_tag_q[$];
   bit            exp_last_q[$];
   int            ren_tag_q[$];
   logic [DW-1:0] ret_data_q[$];
   beat_t         pend[$];
   int            last_due;
   int            bad_last_tag;
   int            lat_fixed;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, act[63:0], exp[63:0]);
      end
   endtask

   task automatic clr_model();
      alloc_q.delete();
      exp_tag_q.delete();
      exp_last_q.delete();
      ren_tag_q.delete();
      ret_data_q.delete();
      pend.delete();
      for (int i = 0; i < NT; i++) begin
         mbcnt[i] = 0;
         mdone[i] = 0;
         idx[i]   = 0;
      end
      next_tag     = 0;
      m_live       = 0;
      last_due     = cyc;
      bad_last_tag = -1;
   endtask

   task automatic model_alloc(input int t);
      alloc_q.push_back(t);
      mdone[t] = 0;
      idx[t]   = 0;
      m_live++;
      next_tag = (next_tag + 1) % NT;
   endtask

   // A completed head tag releases its beats into the expected streams, in allocation order
   task automatic model_cpl(input int t, input int b);
      mbcnt[t] = (b == 0) ? 1 : b;
      mdone[t] = 1;
      while (alloc_q.size() != 0 && mdone[alloc_q[0]]) begin
         int h;
         h = alloc_q.pop_front();
         for (int k = 0; k < mbcnt[h]; k++) begin
            exp_tag_q.push_back(h);
            exp_last_q.push_back(k == mbcnt[h] - 1);
            ren_tag_q.push_back(h);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge dma_clk);
      rst = 1'b1;
      alloc_req = 1'b0;
      cpl_vld = 1'b0;
      @(negedge dma_clk);
      rst = 1'b0;
      #1;
      chk("rst_ren", ft_rd_rsp_ren, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_alloc_gnt", alloc_gnt, 0);
      repeat (5) @(negedge dma_clk);
      clr_model();
   endtask

   task automatic alloc_n(input int n, input bit exp_gnt);
      for (int i = 0; i < n; i++) begin
         @(negedge dma_clk);
         alloc_req = 1'b1;
         #1;
         chk("alloc_gnt", alloc_gnt, exp_gnt);
         if (exp_gnt && alloc_gnt) begin
            chk("alloc_tag", alloc_tag, next_tag);
            model_alloc(next_tag);
         end
      end
      @(negedge dma_clk);
      alloc_req = 1'b0;
   endtask

   task automatic cpl(input int t, input int b, input bit legal);
      @(negedge dma_clk);
      cpl_vld  = 1'b1;
      cpl_tag  = TL'(t);
      cpl_bcnt = BW'(b);
      if (legal) model_cpl(t, b);
      @(negedge dma_clk);
      cpl_vld = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_tag_q.size() != 0 || pend.size() != 0) && n < budget) begin
         @(negedge dma_clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL drain_timeout: %0d beats pending, want 0", exp_tag_q.size());
      end
      repeat (6) @(negedge dma_clk);
   endtask

   initial forever begin
      @(posedge dma_clk);
      cyc++;
   end

   // Fetch-port responder: in-order returns 1..3 cycles after each ren
   initial forever begin
      @(negedge dma_clk);
      ft_rd_rsp_vld  = 1'b0;
      ft_rd_rsp_last = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         beat_t b;
         b = pend.pop_front();
         ft_rd_rsp_vld  = 1'b1;
         ft_rd_rsp_data = b.d;
         ft_rd_rsp_last = b.last;
         ret_data_q.push_back(b.d);
      end
      if (ft_rd_rsp_ren === 1'b1 && !rst) begin
         beat_t nb;
         int t;
         int lat;
         t = int'(ft_rd_rsp_tag);
         idx[t]++;
         lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
         nb.due = cyc + lat;
         if (nb.due <= last_due) nb.due = last_due + 1;
         last_due = nb.due;
         for (int w = 0; w < DW / 32; w++) nb.d[w*32 +: 32] = $urandom();
         nb.last = (t == bad_last_tag) ? (idx[t] == 1) : (idx[t] == mbcnt[t]);
         pend.push_back(nb);
      end
   end

   // Monitor: pops expected fetches and output beats as the DUT presents them
   initial forever begin
      @(negedge dma_clk);
      #2;
      if (!rst) begin
         if (ft_rd_rsp_ren === 1'b1) begin
            ren_cnt++;
            if (ren_tag_q.size() == 0) begin
               total++; bad++;
               $display("FAIL ren_extra: got ren for tag %0d, want none", ft_rd_rsp_tag);
            end else begin
               chk("ren_tag", ft_rd_rsp_tag, ren_tag_q.pop_front());
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_tag_q.size() == 0 || ret_data_q.size() == 0) begin
               total++; bad++;
               $display("FAIL out_extra: got beat tag %0d, want none", out_tag);
            end else begin
               bit el;
               el = exp_last_q.pop_front();
               chk("out_tag", out_tag, exp_tag_q.pop_front());
               chk("out_last", out_last, el);
               chk_d("out_data", out_data, ret_data_q.pop_front());
               if (el) m_live--;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      int got;
      int t;
      int b;
      int cand[$];
      int rem[$];
      rst = 1'b1; alloc_req = 1'b0; cpl_vld = 1'b0; cpl_tag = '0; cpl_bcnt = '0;
      out_ready = 1'b1; ft_rd_rsp_vld = 1'b0; ft_rd_rsp_data = '0; ft_rd_rsp_last = 1'b0;
      lat_fixed = 0;
      clr_model();
      repeat (3) @(negedge dma_clk);
      do_reset();

      // Three grants, no fetch activity
      alloc_n(3, 1'b1);
      #1;
      chk("t1_outstanding", outstanding, 3);
      chk("t1_no_ren", ren_cnt, 0);

      // Out-of-order completions, latency 1
      lat_fixed = 1;
      cpl(2, 1, 1'b1);
      cpl(0, 2, 1'b1);
      cpl(1, 3, 1'b1);
      wait_drain(200);
      chk("t2_outstanding", outstanding, 0);
      chk("t2_err", err, 0);

      // Backpressure: credits cap fetches at 4
      out_ready = 1'b0;
      alloc_n(1, 1'b1);
      rc = ren_cnt;
      cpl(3, 8, 1'b1);
      repeat (20) @(negedge dma_clk);
      #1;
      chk("t3_stall_ren", ren_cnt - rc, 4);
      chk("t3_out_valid", out_valid, 1);
      @(negedge dma_clk);
      out_ready = 1'b1;
      wait_drain(200);
      chk("t3_total_ren", ren_cnt - rc, 8);
      lat_fixed = 0;

      // Full table, wrap of tag 0 after its release
      do_reset();
      alloc_n(64, 1'b1);
      alloc_n(1, 1'b0);
      #1;
      chk("t4_full", outstanding, 64);
      cpl(0, 1, 1'b1);
      got = 0;
      for (int n = 0; n < 40 && got == 0; n++) begin
         @(negedge dma_clk);
         alloc_req = 1'b1;
         #1;
         if (alloc_gnt) begin
            got = 1;
            chk("t4_wrap_tag", alloc_tag, 0);
            chk("t4_wrap_outstanding", outstanding, 63);
            model_alloc(next_tag);
         end
      end
      @(negedge dma_clk);
      alloc_req = 1'b0;
      chk("t4_wrap_granted", got, 1);
      wait_drain(100);
      chk("t4_refull", outstanding, 64);

      // Randomized traffic
      do_reset();
      for (int it = 0; it < 400; it++) begin
         @(negedge dma_clk);
         alloc_req = 1'b0;
         cpl_vld   = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         cand.delete();
         foreach (alloc_q[i]) if (!mdone[alloc_q[i]]) cand.push_back(alloc_q[i]);
         if ($urandom_range(0, 2) == 0 && m_live < 60) alloc_req = 1'b1;
         if ($urandom_range(0, 2) == 0 && cand.size() != 0) begin
            t = cand[$urandom_range(0, cand.size() - 1)];
            b = int'($urandom_range(1, 6));
            cpl_vld  = 1'b1;
            cpl_tag  = TL'(t);
            cpl_bcnt = BW'(b);
            model_cpl(t, b);
         end
         #1;
         if (alloc_req) begin
            chk("t5_gnt", alloc_gnt, 1);
            chk("t5_tag", alloc_tag, next_tag);
            model_alloc(next_tag);
         end
      end
      @(negedge dma_clk);
      alloc_req = 1'b0;
      cpl_vld   = 1'b0;
      out_ready = 1'b1;
      rem.delete();
      foreach (alloc_q[i]) if (!mdone[alloc_q[i]]) rem.push_back(alloc_q[i]);
      foreach (rem[i]) cpl(rem[i], int'($urandom_range(1, 4)), 1'b1);
      wait_drain(3000);
      chk("t5_outstanding", outstanding, 0);
      chk("t5_err", err, 0);

      // Completion for an unallocated tag
      do_reset();
      alloc_n(2, 1'b1);
      cpl(5, 3, 1'b0);
      #1;
      chk("t6_err", err, 1);
      cpl(0, 2, 1'b1);
      cpl(1, 1, 1'b1);
      wait_drain(200);
      chk("t6_outstanding", outstanding, 0);
      chk("t6_err_sticky", err, 1);

      // Early last flag from the buffer
      do_reset();
      alloc_n(1, 1'b1);
      bad_last_tag = 0;
      cpl(0, 2, 1'b1);
      wait_drain(200);
      chk("t7_err", err, 1);
      bad_last_tag = -1;
      alloc_n(1, 1'b1);
      cpl(1, 3, 1'b1);
      wait_drain(200);
      chk("t7_outstanding", outstanding, 0);

      // Reset during FETCH
      do_reset();
      out_ready = 1'b0;
      alloc_n(2, 1'b1);
      rc = ren_cnt;
      cpl(0, 8, 1'b1);
      for (int n = 0; n < 20 && ren_cnt == rc; n++) @(negedge dma_clk);
      chk("t8_fetch_started", ren_cnt != rc, 1);
      do_reset();
      alloc_n(1, 1'b1);
      out_ready = 1'b1;
      cpl(0, 1, 1'b1);
      wait_drain(200);
      chk("t8_outstanding", outstanding, 0);
      chk("t8_err", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
